data_mem_responder: RTL and testbench

//  Memory-side responder for the pipeline's data-memory port: accepts one load/store request per handshake.

---
 rtl/data_mem_responder.sv | 157 +++++++++++++++
 tb/tb_data_mem_responder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
// Data-memory responder: serves one aligned big-endian load/store at a time from an internal byte array.
// Latency: resp_valid is seen LATENCY cycles after the request handshake cycle.
// Backpressure: req_ready stays low from acceptance until the response handshake; the response is held while resp_ready is low.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_read,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          lat_write;
    logic          lat_err;
    logic [AW-1:0] lat_addr;
    logic [63:0]   lat_wdata;
    logic [3:0]    lat_nbytes;

    logic [7:0]    mem [DEPTH_BYTES];

    logic          size_ok;
    logic          misaligned;
    logic          out_of_range;
    logic          req_err;
    logic [64:0]   req_end;
    logic          accept;
    logic          enter_resp;
    logic          acc_write;
    logic          acc_err;
    logic [AW-1:0] acc_addr;
    logic [63:0]   acc_wdata;
    logic [3:0]    acc_nbytes;
    logic [6:0]    pad_bits;
    logic [63:0]   rd_left;
    logic [63:0]   wr_left;
    logic [63:0]   load_data;

    // Range check is done on the full 65-bit sum so addresses near 2^64 cannot wrap into range.
    always_comb begin
        size_ok      = (req_size == 4'd1) || (req_size == 4'd2) ||
                       (req_size == 4'd4) || (req_size == 4'd8);
        misaligned   = (req_addr[3:0] & (req_size - 4'd1)) != 4'd0;
        req_end      = {1'b0, req_addr} + {61'd0, req_size};
        out_of_range = req_end > 65'(DEPTH_BYTES);
        req_err      = (req_read == req_write) || !size_ok || misaligned || out_of_range;
    end

    assign accept     = (state == ST_IDLE) && req_valid && req_ready;
    assign enter_resp = (LATENCY == 1) ? accept : ((state == ST_BUSY) && (cnt == 4'd1));

    // With LATENCY==1 the access happens on the accept edge, so the live request feeds the array directly.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_write  = req_write;
            acc_err    = req_err;
            acc_addr   = req_addr[AW-1:0];
            acc_wdata  = req_wdata;
            acc_nbytes = req_size;
        end else begin
            acc_write  = lat_write;
            acc_err    = lat_err;
            acc_addr   = lat_addr;
            acc_wdata  = lat_wdata;
            acc_nbytes = lat_nbytes;
        end
        pad_bits = 7'd8 * (7'd8 - {3'd0, acc_nbytes});
        wr_left  = acc_wdata << pad_bits;
        rd_left  = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(acc_nbytes)) begin
                rd_left[63-8*i -: 8] = mem[acc_addr + AW'(i)];
            end
        end
        load_data = (acc_err || acc_write) ? 64'd0 : (rd_left >> pad_bits);
    end

    always_ff @(posedge clk) begin
        if (reset && enter_resp && acc_write && !acc_err) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(acc_nbytes)) begin
                    mem[acc_addr + AW'(i)] <= wr_left[63-8*i -: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_write  <= 1'b0;
            lat_err    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_nbytes <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_write  <= req_write;
                        lat_err    <= req_err;
                        lat_addr   <= req_addr[AW-1:0];
                        lat_wdata  <= req_wdata;
                        lat_nbytes <= req_size;
                        cnt        <= 4'(LATENCY - 1);
                        req_ready  <= 1'b0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - 4'd1;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (enter_resp) begin
                state      <= ST_RESP;
                cnt        <= '0;
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                resp_rdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
// Bench for data_mem_responder: three instances (LATENCY 3, 1, 15) checked against a byte-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int ND    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [ND];
    logic        req_ready  [ND];
    logic        req_write  [ND];
    logic        req_read   [ND];
    logic [63:0] req_addr   [ND];
    logic [63:0] req_wdata  [ND];
    logic [3:0]  req_size   [ND];
    logic        resp_valid [ND];
    logic        resp_ready [ND];
    logic [63:0] resp_rdata [ND];
    logic        resp_err   [ND];

    logic [7:0]  mm [ND][DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < ND; g++) begin : g_dut
            data_mem_responder #(
                .DEPTH_BYTES(DEPTH),
                .LATENCY    (g == 0 ? 3 : (g == 1 ? 1 : 15))
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .req_valid (req_valid[g]),
                .req_ready (req_ready[g]),
                .req_write (req_write[g]),
                .req_read  (req_read[g]),
                .req_addr  (req_addr[g]),
                .req_wdata (req_wdata[g]),
                .req_size  (req_size[g]),
                .resp_valid(resp_valid[g]),
                .resp_ready(resp_ready[g]),
                .resp_rdata(resp_rdata[g]),
                .resp_err  (resp_err[g])
            );
        end
    endgenerate

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : ((d == 1) ? 1 : 15);
    endfunction

    // Reference: decide legality from the request rules, then read or write bytes big-endian.
    function automatic void model(input int d, input logic w, input logic r, input logic [63:0] a,
                                  input logic [63:0] wd, input logic [3:0] sz,
                                  output logic [63:0] rd, output logic err);
        int n;
        int base;
        n   = int'(sz);
        rd  = '0;
        err = (w == r) || !(n == 1 || n == 2 || n == 4 || n == 8);
        if (!err) err = ((a % 64'(n)) != 64'd0) || (a > 64'(DEPTH - n));
        if (err) return;
        base = int'(a[31:0]);
        for (int i = 0; i < n; i++) begin
            if (r) rd = (rd << 8) | 64'(mm[d][base + i]);
            else   mm[d][base + i] = 8'(wd >> (8 * (n - 1 - i)));
        end
    endfunction

    task automatic send_req(input int d, input logic w, input logic r, input logic [63:0] a,
                            input logic [63:0] wd, input logic [3:0] sz, output bit ok, output int wc);
        ok = 1'b0;
        wc = 0;
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_read[d]  = r;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_size[d]  = sz;
        for (int c = 0; c < 50; c++) begin
            if (req_ready[d]) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            wc++;
        end
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom);
        req_read[d]  = 1'($urandom);
        req_addr[d]  = {$urandom, $urandom};
        req_wdata[d] = {$urandom, $urandom};
        req_size[d]  = 4'($urandom);
    endtask

    task automatic wait_resp(input int d, output bit ok, output int lat);
        ok  = 1'b0;
        lat = 1;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid[d]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume(input int d);
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
    endtask

    task automatic xact(input int d, input logic w, input logic r, input logic [63:0] a,
                        input logic [63:0] wd, input logic [3:0] sz,
                        output logic [63:0] rd, output logic e, output int lat, output bit ok);
        int wc;
        bit ok1;
        bit ok2;
        ok2 = 1'b0;
        lat = 0;
        send_req(d, w, r, a, wd, sz, ok1, wc);
        if (ok1) wait_resp(d, ok2, lat);
        rd = resp_rdata[d];
        e  = resp_err[d];
        if (ok2) consume(d);
        ok = ok1 && ok2;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_read[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; req_size[d] = '0; resp_ready[d] = 1'b0;
        end
        #1 reset = 1'b0;
        #20;
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 64'd0 || resp_err[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
        #3 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_preload;
        logic [63:0] rd, exp_rd, wd;
        logic e, exp_e;
        int lat;
        bit ok;
        for (int d = 0; d < ND; d++) begin
            for (int a = 0; a < DEPTH; a += 8) begin
                wd = {$urandom, $urandom};
                model(d, 1'b1, 1'b0, 64'(a), wd, 4'd8, exp_rd, exp_e);
                xact(d, 1'b1, 1'b0, 64'(a), wd, 4'd8, rd, e, lat, ok);
                n_checks++;
                if (!ok || e !== exp_e || rd !== exp_rd) begin
                    n_fail++;
                    $display("FAIL preload dut%0d @%0h: ok=%b err=%b rdata=%h, required ok=1 err=%b rdata=%h",
                             d, a, ok, e, rd, exp_e, exp_rd);
                end
            end
        end
    endtask

    task automatic test_basic(input int d);
        logic [63:0] rd, exp_rd;
        logic e, exp_e;
        int lat;
        bit ok;
        model(d, 1'b1, 1'b0, 64'h10, 64'h0123_4567_89AB_CDEF, 4'd8, exp_rd, exp_e);
        xact(d, 1'b1, 1'b0, 64'h10, 64'h0123_4567_89AB_CDEF, 4'd8, rd, e, lat, ok);
        n_checks++;
        if (!ok || lat != lat_of(d) || e !== 1'b0 || rd !== 64'd0) begin
            n_fail++;
            $display("FAIL basic_store dut%0d: ok=%b lat=%0d err=%b rdata=%h, required ok=1 lat=%0d err=0 rdata=0",
                     d, ok, lat, e, rd, lat_of(d));
        end
        model(d, 1'b0, 1'b1, 64'h10, 64'd0, 4'd8, exp_rd, exp_e);
        xact(d, 1'b0, 1'b1, 64'h10, 64'd0, 4'd8, rd, e, lat, ok);
        n_checks++;
        if (!ok || lat != lat_of(d) || e !== 1'b0 || rd !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL basic_load dut%0d: ok=%b lat=%0d err=%b rdata=%h, required ok=1 lat=%0d err=0 rdata=0123456789abcdef",
                     d, ok, lat, e, rd, lat_of(d));
        end
    endtask

    task automatic test_subword;
        logic [63:0] rd, exp_rd;
        logic e, exp_e;
        int lat;
        bit ok;
        model(0, 1'b0, 1'b1, 64'h10, 64'd0, 4'd1, exp_rd, exp_e);
        xact(0, 1'b0, 1'b1, 64'h10, 64'd0, 4'd1, rd, e, lat, ok);
        n_checks++;
        if (!ok || e !== 1'b0 || rd !== 64'h01) begin
            n_fail++;
            $display("FAIL load1B: ok=%b err=%b rdata=%h, required 1 0 01", ok, e, rd);
        end
        xact(0, 1'b0, 1'b1, 64'h16, 64'd0, 4'd2, rd, e, lat, ok);
        n_checks++;
        if (!ok || e !== 1'b0 || rd !== 64'hCDEF) begin
            n_fail++;
            $display("FAIL load2B: ok=%b err=%b rdata=%h, required 1 0 cdef", ok, e, rd);
        end
        model(0, 1'b1, 1'b0, 64'h14, 64'hDEAD_BEEF, 4'd4, exp_rd, exp_e);
        xact(0, 1'b1, 1'b0, 64'h14, 64'hDEAD_BEEF, 4'd4, rd, e, lat, ok);
        n_checks++;
        if (!ok || e !== 1'b0 || rd !== 64'd0) begin
            n_fail++;
            $display("FAIL store4B: ok=%b err=%b rdata=%h, required 1 0 0", ok, e, rd);
        end
        xact(0, 1'b0, 1'b1, 64'h10, 64'd0, 4'd8, rd, e, lat, ok);
        n_checks++;
        if (!ok || e !== 1'b0 || rd !== 64'h0123_4567_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL load_after_store4B: ok=%b err=%b rdata=%h, required 1 0 01234567deadbeef", ok, e, rd);
        end
    endtask

    task automatic test_errors;
        logic [63:0] rd;
        logic e;
        int lat;
        bit ok;
        logic        ew [6];
        logic        er [6];
        logic [63:0] ea [6];
        logic [3:0]  es [6];
        ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        er = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ea = '{64'h12, 64'(DEPTH), 64'h10, 64'h10, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8};
        es = '{4'd4, 4'd8, 4'b0011, 4'd8, 4'd8, 4'd8};
        for (int k = 0; k < 6; k++) begin
            xact(0, ew[k], er[k], ea[k], 64'hFFFF_FFFF_FFFF_FFFF, es[k], rd, e, lat, ok);
            n_checks++;
            if (!ok || lat != 3 || e !== 1'b1 || rd !== 64'd0) begin
                n_fail++;
                $display("FAIL error_case%0d: ok=%b lat=%0d err=%b rdata=%h, required ok=1 lat=3 err=1 rdata=0",
                         k, ok, lat, e, rd);
            end
        end
        xact(0, 1'b0, 1'b1, 64'h10, 64'd0, 4'd8, rd, e, lat, ok);
        n_checks++;
        if (!ok || e !== 1'b0 || rd !== 64'h0123_4567_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL error_no_side_effect: ok=%b err=%b rdata=%h, required 1 0 01234567deadbeef", ok, e, rd);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] exp_rd;
        logic exp_e;
        bit ok, ok2;
        int lat, wc;
        model(0, 1'b0, 1'b1, 64'h10, 64'd0, 4'd8, exp_rd, exp_e);
        send_req(0, 1'b0, 1'b1, 64'h10, 64'd0, 4'd8, ok, wc);
        wait_resp(0, ok2, lat);
        n_checks++;
        if (!ok || !ok2 || lat != 3) begin
            n_fail++;
            $display("FAIL bp_arrival: ok=%b/%b lat=%0d, required 1/1 lat=3", ok, ok2, lat);
        end
        for (int c = 0; c < 5; c++) begin
            req_valid[0] = (c % 2 == 0);
            req_write[0] = 1'b1;
            req_read[0]  = 1'b0;
            req_addr[0]  = 64'h10;
            req_wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
            req_size[0]  = 4'd8;
            n_checks++;
            if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== exp_rd || resp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle%0d: valid=%b rdata=%h err=%b ready=%b, required 1 %h 0 0",
                         c, resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0], exp_rd);
            end
            @(posedge clk); #1;
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        n_checks++;
        if (req_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_consume_ready: req_ready=%b, required 0", req_ready[0]);
        end
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        n_checks++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_after_consume: valid=%b ready=%b, required 0 1", resp_valid[0], req_ready[0]);
        end
        send_req(0, 1'b0, 1'b1, 64'h10, 64'd0, 4'd8, ok, wc);
        wait_resp(0, ok2, lat);
        n_checks++;
        if (!ok || !ok2 || wc != 0 || resp_rdata[0] !== exp_rd) begin
            n_fail++;
            $display("FAIL bp_next_request: ok=%b/%b wait=%0d rdata=%h, required 1/1 0 %h",
                     ok, ok2, wc, resp_rdata[0], exp_rd);
        end
        if (ok2) consume(0);
    endtask

    task automatic test_reset_midaccess;
        logic [63:0] rd, exp_rd;
        logic e, exp_e;
        int lat, wc;
        bit ok;
        send_req(0, 1'b1, 1'b0, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, ok, wc);
        @(posedge clk); #1;
        n_checks++;
        if (!ok || req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_busy: ok=%b ready=%b valid=%b, required 1 0 0", ok, req_ready[0], resp_valid[0]);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || resp_rdata[0] !== 64'd0 || resp_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                     req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0]);
        end
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        model(0, 1'b0, 1'b1, 64'h20, 64'd0, 4'd8, exp_rd, exp_e);
        xact(0, 1'b0, 1'b1, 64'h20, 64'd0, 4'd8, rd, e, lat, ok);
        n_checks++;
        if (!ok || e !== 1'b0 || rd !== exp_rd) begin
            n_fail++;
            $display("FAIL midreset_store_dropped: ok=%b err=%b rdata=%h, required 1 0 %h", ok, e, rd, exp_rd);
        end
    endtask

    task automatic test_random;
        logic [63:0] rd, exp_rd, a, wd;
        logic e, exp_e, w, r;
        logic [3:0] sz;
        int lat, n;
        bit ok;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) sz = 4'($urandom);
            else                           sz = 4'(1 << $urandom_range(0, 3));
            n = (int'(sz) == 0) ? 1 : int'(sz);
            case ($urandom_range(0, 9))
                0:       a = {$urandom, $urandom};
                1:       a = 64'(DEPTH - n + int'($urandom_range(0, 8)));
                2:       a = 64'($urandom_range(0, DEPTH - 1));
                default: a = 64'($urandom_range(0, DEPTH / n - 1) * n);
            endcase
            w = 1'($urandom);
            r = ($urandom_range(0, 9) == 0) ? w : !w;
            wd = {$urandom, $urandom};
            model(0, w, r, a, wd, sz, exp_rd, exp_e);
            xact(0, w, r, a, wd, sz, rd, e, lat, ok);
            n_checks++;
            if (!ok || lat != 3 || e !== exp_e || rd !== exp_rd) begin
                n_fail++;
                $display("FAIL random%0d w=%b r=%b a=%h sz=%h: ok=%b lat=%0d err=%b rdata=%h, required 1 3 %b %h",
                         k, w, r, a, sz, ok, lat, e, rd, exp_e, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        for (int d = 0; d < ND; d++) test_basic(d);
        test_subword();
        test_errors();
        test_backpressure();
        test_reset_midaccess();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
